// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bus status addresses and
// config register bit positions used by both the Tx and Rx paths.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2
   } rx_state_t;

   localparam logic [31:0] TX_STAT_ADDR      = 32'h1;
   localparam logic [31:0] RX_STAT_ADDR_DFLT = 32'h2;

   localparam int unsigned CFG_EN       = 0;
   localparam int unsigned CFG_TWO_STOP = 1;
   localparam int unsigned CFG_ODD_PAR  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: config register, line synchronizer, start-validating frame FSM
// and a single-entry holding register with sticky status flags.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] RX_STAT_ADDR = RX_STAT_ADDR_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        config_en,
   input  logic        Rx_en,
   input  logic        Two_stop,
   input  logic        Odd_parity,
   input  logic        rx_serial,
   input  logic        rd_en,
   input  logic [31:0] addr,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        overrun_err,
   output logic        busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

   logic [2:0]      cfg_q;
   logic            rx_en_r;
   logic            rx_s, rx_prev_q, fall;
   rx_state_t       state_q, state_d;
   logic [CntW-1:0] bit_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            two_stop_q, odd_par_q, par_fail_q, stop_fail_q, done_q;
   logic            half_hit, full_hit, clr;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_serial),
      .q     (rx_s)
   );

   assign rx_en_r  = cfg_q[CFG_EN];
   assign fall     = ~rx_s & rx_prev_q;
   assign half_hit = (bit_cnt_q == HalfCnt);
   assign full_hit = (bit_cnt_q == FullCnt);
   assign clr      = rd_en && (addr == RX_STAT_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q     <= '0;
         rx_prev_q <= 1'b1;
         state_q   <= StIdle;
      end else begin
         if (config_en) begin
            cfg_q[CFG_EN]       <= Rx_en;
            cfg_q[CFG_TWO_STOP] <= Two_stop;
            cfg_q[CFG_ODD_PAR]  <= Odd_parity;
         end
         rx_prev_q <= rx_s;
         state_q   <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!rx_en_r) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:   if (fall) state_d = StStart;
            StStart:  if (half_hit) state_d = rx_s ? StIdle : StData;
            StData:   if (full_hit && bit_idx_q == 3'd7) state_d = StParity;
            StParity: if (full_hit) state_d = StStop1;
            StStop1:  if (full_hit) state_d = two_stop_q ? StStop2 : StIdle;
            StStop2:  if (full_hit) state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != StIdle);
   end

   // Bit timing and sampling; done_q pulses the cycle after the final stop sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         two_stop_q  <= 1'b0;
         odd_par_q   <= 1'b0;
         par_fail_q  <= 1'b0;
         stop_fail_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == StIdle || state_d != state_q || full_hit) begin
            bit_cnt_q <= '0;
         end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
         end
         if (rx_en_r) begin
            case (state_q)
               StIdle: begin
                  if (fall) begin
                     two_stop_q <= cfg_q[CFG_TWO_STOP];
                     odd_par_q  <= cfg_q[CFG_ODD_PAR];
                  end
               end
               StStart: begin
                  if (half_hit && !rx_s) begin
                     bit_idx_q   <= '0;
                     stop_fail_q <= 1'b0;
                  end
               end
               StData: begin
                  if (full_hit) begin
                     shift_q[bit_idx_q] <= rx_s;
                     bit_idx_q          <= bit_idx_q + 3'd1;
                  end
               end
               StParity: begin
                  if (full_hit) par_fail_q <= ((^shift_q) ^ rx_s) != odd_par_q;
               end
               StStop1: begin
                  if (full_hit) begin
                     stop_fail_q <= ~rx_s;
                     done_q      <= ~two_stop_q;
                  end
               end
               StStop2: begin
                  if (full_hit) begin
                     stop_fail_q <= stop_fail_q | ~rx_s;
                     done_q      <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Clear is applied before completion so a same-cycle read never loses the new byte.
   always_comb begin
      rx_data_d = rx_data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      oerr_d    = oerr_q;
      if (clr) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         oerr_d  = 1'b0;
      end
      if (done_q) begin
         if (!valid_d) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
            perr_d    = perr_d | par_fail_q;
            ferr_d    = ferr_d | stop_fail_q;
         end else begin
            oerr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         oerr_q    <= 1'b0;
      end else begin
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         oerr_q    <= oerr_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are serialised at CPB clocks per bit,
// a reference model predicts status, and a monitor checks each newly presented byte.
module tb_uart_rx_core;

   localparam int unsigned CPB = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        config_en = 1'b0;
   logic        Rx_en = 1'b0;
   logic        Two_stop = 1'b0;
   logic        Odd_parity = 1'b0;
   logic        rx_serial = 1'b1;
   logic        rd_en = 1'b0;
   logic [31:0] addr = '0;
   logic [7:0]  rx_data;
   logic        rx_valid, parity_err, frame_err, overrun_err, busy;

   uart_rx_core #(
      .CLKS_PER_BIT (CPB),
      .RX_STAT_ADDR (32'h2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .config_en   (config_en),
      .Rx_en       (Rx_en),
      .Two_stop    (Two_stop),
      .Odd_parity  (Odd_parity),
      .rx_serial   (rx_serial),
      .rd_en       (rd_en),
      .addr        (addr),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  data;
      logic        perr;
      logic        ferr;
      int unsigned when;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model of the visible receiver state.
   logic       m_valid = 0, m_perr = 0, m_ferr = 0, m_oerr = 0;
   logic [7:0] m_data = '0;
   bit         cfg_two = 0, cfg_odd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic model_clear();
      m_valid = 0;
      m_perr  = 0;
      m_ferr  = 0;
      m_oerr  = 0;
   endtask

   task automatic configure(input bit en, input bit two, input bit odd);
      config_en  = 1;
      Rx_en      = en;
      Two_stop   = two;
      Odd_parity = odd;
      @(posedge clk);
      #1;
      config_en = 0;
      cfg_two   = two;
      cfg_odd   = odd;
   endtask

   task automatic bus_read(input logic [31:0] a);
      rd_en = 1;
      addr  = a;
      @(posedge clk);
      #1;
      rd_en = 0;
      addr  = '0;
      if (a == 32'h2) model_clear();
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(m_valid));
      chk({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
      chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
      chk({tag, ".overrun_err"}, 32'(overrun_err), 32'(m_oerr));
   endtask

   // Must be called just after a clock edge. Frame outcome is predicted at issue time:
   // completion lands one clock after the final stop centre, i.e. 2 sync + 1 detect +
   // half a bit + 10 (or 11) whole bits after the start bit is driven.
   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                             input logic s2, input int nbits, input bit expect_done,
                             input bit clr_at_done);
      logic [11:0] bits;
      int          nfr;
      int unsigned n0;
      bit          pf, ff;
      bits = {s2, s1, pbit, d, 1'b0};
      nfr  = cfg_two ? 12 : 11;
      n0   = cyc;
      if (expect_done) begin
         pf = ((($countones(d) + int'(pbit)) % 2) != int'(cfg_odd));
         ff = !s1 || (cfg_two && !s2);
         if (clr_at_done) model_clear();
         if (!m_valid) begin
            m_valid = 1;
            m_data  = d;
            m_perr  = m_perr | pf;
            m_ferr  = m_ferr | ff;
            exp_q.push_back('{d, pf, ff, n0 + 172 + (cfg_two ? 16 : 0)});
         end else begin
            m_oerr = 1;
         end
      end
      for (int i = 0; i < nfr && i < nbits; i++) begin
         rx_serial = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx_serial = 1;
   endtask

   // Monitor: a byte is presented when rx_valid rises or the held byte changes.
   logic       prev_valid = 0;
   logic [7:0] prev_data = '0;
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rx_valid && (!prev_valid || rx_data != prev_data)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon.unexpected: got byte %0h want none (cycle %0d)", rx_data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("mon.data", 32'(rx_data), 32'(e.data));
            chk("mon.parity_err", 32'(parity_err), 32'(e.perr));
            chk("mon.frame_err", 32'(frame_err), 32'(e.ferr));
            chk("mon.cycle", cyc, e.when);
         end
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
   end

   initial begin
      logic [7:0] d;
      bit         two, odd, good;
      logic       pbit, s1, s2;

      repeat (3) @(posedge clk);
      #1;
      check_status("reset");
      chk("reset.busy", 32'(busy), 0);
      reset = 1;
      @(posedge clk);
      #1;

      // Even parity, one stop bit, clean byte, then clear by read.
      configure(1, 0, 0);
      send_frame(8'hA5, 0, 1, 1, 12, 1, 0);
      check_status("a5");
      bus_read(32'h2);
      check_status("a5.clr");

      // Odd parity, two stops: bad parity, then bad second stop.
      configure(1, 1, 1);
      send_frame(8'h3C, 0, 1, 1, 12, 1, 0);
      check_status("3c.perr");
      bus_read(32'h2);
      send_frame(8'h5A, 1, 1, 0, 12, 1, 0);
      check_status("5a.ferr");
      bus_read(32'h2);

      // Short low glitch is rejected at the start-bit centre.
      rx_serial = 0;
      repeat (4) @(posedge clk);
      #1;
      rx_serial = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("glitch.busy_hi", 32'(busy), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("glitch.busy_lo", 32'(busy), 0);
      check_status("glitch");

      // Overrun, then clear coinciding with completion.
      configure(1, 0, 0);
      send_frame(8'h11, 0, 1, 1, 12, 1, 0);
      send_frame(8'h22, 0, 1, 1, 12, 1, 0);
      check_status("overrun");
      fork
         send_frame(8'h33, 0, 1, 1, 12, 1, 1);
         begin
            repeat (171) @(posedge clk);
            #1;
            rd_en = 1;
            addr  = 32'h2;
            @(posedge clk);
            #1;
            rd_en = 0;
            addr  = '0;
         end
      join
      check_status("clr_and_done");

      // Disable mid-frame: frame dropped, status kept; Tx address read is ignored.
      fork
         send_frame(8'h77, 1, 1, 1, 12, 0, 0);
         begin
            repeat (60) @(posedge clk);
            #1;
            chk("dis.busy_before", 32'(busy), 1);
            configure(0, 0, 0);
            @(posedge clk);
            #1;
            chk("dis.busy_after", 32'(busy), 0);
         end
      join
      check_status("dis");
      bus_read(32'h1);
      check_status("tx_addr_read");

      // Asynchronous reset after three data bits.
      configure(1, 0, 0);
      send_frame(8'h6B, 1, 1, 1, 4, 0, 0);
      chk("rst.busy_before", 32'(busy), 1);
      reset = 0;
      #2;
      m_data  = '0;
      model_clear();
      cfg_two = 0;
      cfg_odd = 0;
      check_status("rst.async");
      chk("rst.busy", 32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1;
      repeat (200) @(posedge clk);
      #1;
      check_status("rst.idle");
      chk("rst.idle_busy", 32'(busy), 0);

      // Break: held-low line gives one frame of zeros with a framing error.
      configure(1, 0, 0);
      send_frame(8'h00, 0, 0, 0, 12, 1, 0);
      rx_serial = 0;
      repeat (100) @(posedge clk);
      #1;
      check_status("break");
      chk("break.busy", 32'(busy), 0);
      rx_serial = 1;
      repeat (20) @(posedge clk);
      #1;
      bus_read(32'h2);

      // Randomised frames over all configurations.
      for (int k = 0; k < 12; k++) begin
         two  = 1'($urandom % 2);
         odd  = 1'($urandom % 2);
         configure(1, two, odd);
         d    = 8'($urandom);
         good = 1'(($countones(d) % 2) != 0) ^ odd;
         pbit = ($urandom % 4 == 0) ? ~good : good;
         s1   = ($urandom % 5 != 0);
         s2   = ($urandom % 5 != 0);
         send_frame(d, pbit, s1, s2, 12, 1, 0);
         check_status("rand");
         bus_read(32'h2);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard.empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver: the receive-side counterpart of the existing UART transmitter path.
- Contains the Rx control/status register, a 2-flop line synchronizer, a start-bit validating FSM, and a single-entry receive holding register.
- Frame format: 1 start bit, 8 data bits LSB-first, 1 parity bit (always present), 1 or 2 stop bits.
- Sits beside the Tx path on the same peripheral bus and is configured the same way (config_en strobe).

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (must be >= 4; even value recommended).
- RX_STAT_ADDR, 32'h2, bus address whose read clears receive status.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- config_en  in  1  latch Rx_en/Two_stop/Odd_parity into the config register
- Rx_en  in  1  receiver enable
- Two_stop  in  1  1 = two stop bits expected
- Odd_parity  in  1  1 = odd parity, 0 = even parity
- rx_serial  in  1  asynchronous serial line, idle high
- rd_en  in  1  bus read strobe
- addr  in  32  bus address
- rx_data  out  8  last received byte (holding register)
- rx_valid  out  1  holding register contains unread data
- parity_err  out  1  sticky parity error
- frame_err  out  1  sticky framing error (stop bit sampled 0)
- overrun_err  out  1  sticky: frame completed while rx_valid was 1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-low):
  - All outputs = 0; config register = 0; FSM = IDLE; counters = 0.
  - Synchronizer flops reset to 1 (idle line).
- Config register:
  - On a clk edge with config_en=1, load {Odd_parity, Two_stop, Rx_en}.
  - The FSM snapshots Two_stop/Odd_parity at start-bit detection; config changes mid-frame affect only the next frame.
- Rx_en_r = 0: FSM forced to IDLE on the next edge, any in-progress frame is discarded, status is untouched.
- Line: rx_s = rx_serial after two flops. Falling edge = rx_s 0 with previous rx_s 1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Bit counter bit_cnt counts 0..CLKS_PER_BIT-1.
  - IDLE:
    - Falling edge with Rx_en_r=1 -> START, bit_cnt cleared.
  - START:
    - At bit_cnt = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - rx_s = 0 -> DATA, bit_cnt cleared, bit index = 0.
    - rx_s = 1 -> IDLE (glitch rejected, no status change).
  - DATA:
    - At each bit_cnt = CLKS_PER_BIT-1, shift rx_s into shift[bit index] (LSB first).
    - After index 7 -> PARITY.
  - PARITY:
    - Sample at the bit centre.
    - Error if (^shift ^ sampled) != Odd_parity snapshot (odd: data+parity has odd ones; even: even ones).
  - STOP1:
    - Sample at the bit centre.
    - Two_stop snapshot = 1 -> STOP2; otherwise complete the frame.
  - STOP2:
    - Sample at the bit centre, then complete the frame.
- Frame completion (on the edge following the final stop sample; latency = 1 clk):
  - rx_valid = 0 beforehand:
    - rx_data <= shift; rx_valid <= 1.
    - parity_err |= parity fail; frame_err |= any stop sample = 0.
    - Data is loaded even on error.
  - rx_valid = 1 beforehand:
    - Holding register is NOT overwritten (new byte dropped); overrun_err <= 1.
    - parity_err/frame_err are not updated.
  - FSM returns to IDLE; a new start can be detected on the following cycle.
- Status clear: rd_en=1 and addr == RX_STAT_ADDR clears rx_valid, parity_err, frame_err and overrun_err on that edge.
- Clear and completion in the same cycle: the clear applies first, then the completion, so the new byte is loaded, rx_valid = 1, and overrun_err = 0.
- busy = 1 in every state except IDLE.
- Break (line held low): yields a frame with frame_err=1 and data 8'h00. The FSM waits in IDLE for the next falling edge, so a held-low line produces no repeated frames.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - TX_STAT_ADDR = 32'h1, RX_STAT_ADDR default 32'h2
  - config bit-index constants (EN=0, TWO_STOP=1, ODD_PAR=2), shared with the Tx side
- One natural sub-module: uart_sync2 (2-flop synchronizer, reset value 1, also reusable on other async inputs).

Test Plan (CLKS_PER_BIT=16):
- config Rx_en=1, even parity, 1 stop; send 8'hA5 with parity 0 -> rx_valid=1 one clk after stop centre, rx_data=8'hA5, all error flags 0; read addr 2 -> rx_valid=0.
- Odd parity, 2 stop bits; send 8'h3C with wrong parity bit 0 -> rx_data=8'h3C, parity_err=1; second stop bit 0 on the next frame -> frame_err=1.
- Low glitch of 4 clks on idle line -> FSM returns to IDLE, busy drops, rx_valid stays 0.
- Two frames 8'h11 then 8'h22 with no read -> rx_data=8'h11, overrun_err=1; rd_en on addr 2 in the completion cycle of a third frame 8'h33 -> rx_data=8'h33, rx_valid=1, overrun_err=0.
- Mid-frame (after 3 data bits) deassert reset -> all outputs 0 immediately (async); after release, line idle -> no spurious rx_valid.
- Mid-frame config_en with Rx_en=0 -> busy=0 next edge, status unchanged; read at addr 1 (Tx address) never clears Rx status.
